mcb_port_responder: RTL and testbench
=====================================

# mcb_port_responder

Synthesizable responder for the MIG Spartan-6 MCB port-0 user interface. It stands in for the `ddr2` memory controller wrapper, so the `ddr2_test` transfer engine can be exercised in simulation and on hardware without a DDR2 device. It accepts commands, write data and read requests on the p0 cmd/wr/rd FIFO ports and answers them from an internal 32-bit-wide RAM, with MCB-like latency, FIFO flags and error reporting.

## Interface
Parameters:
- MEM_ADDR_BITS, 10: log2 of RAM depth in 32-bit words.
- CALIB_CYCLES, 64: cycles from reset release until calib_done rises.
- CMD_LATENCY, 4: cycles the engine waits between popping a command and its first data beat (minimum 1).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; all p0 ports are synchronous to it.
- reset  in  1  asynchronous, active-high.
- calib_done  out  1  high once the responder accepts commands.
- p0_cmd_en  in  1  command push strobe.
- p0_cmd_instr  in  3  command code: 000 write, 001 read, 010 write+AP, 011 read+AP, 1xx refresh/no-op.
- p0_cmd_bl  in  6  burst length minus 1.
- p0_cmd_byte_addr  in  30  byte address.
- p0_cmd_empty  out  1  command FIFO empty.
- p0_cmd_full  out  1  command FIFO full, or calib_done low.
- p0_wr_en  in  1  write-data push strobe.
- p0_wr_mask  in  4  byte mask; bit=1 means the byte is not written.
- p0_wr_data  in  32  write data.
- p0_wr_full  out  1  write FIFO full.
- p0_wr_empty  out  1  write FIFO empty.
- p0_wr_count  out  7  write FIFO occupancy, 0–64.
- p0_wr_underrun  out  1  one-cycle pulse when a write beat finds the write FIFO empty.
- p0_wr_error  out  1  sticky; set on underrun or on a push while full.
- p0_rd_en  in  1  read-data pop strobe.
- p0_rd_data  out  32  head of the read FIFO (first-word fall-through).
- p0_rd_full  out  1  read FIFO full.
- p0_rd_empty  out  1  read FIFO empty.
- p0_rd_count  out  7  read FIFO occupancy, 0–64.
- p0_rd_overflow  out  1  one-cycle pulse when a read beat is dropped because the read FIFO is full.
- p0_rd_error  out  1  sticky; set on overflow or on a pop while empty.

## Operation
- **Reset values.** calib_done=0, p0_cmd_full=1, all empty flags=1, all other full flags=0, counts=0, pulses and sticky errors=0, p0_rd_data=0. RAM contents are not reset and are retained across reset.
- **Calibration.** An internal counter raises calib_done CALIB_CYCLES cycles after reset falls. p0_cmd_full is forced high until then; wr and rd FIFOs operate normally during this period.
- **FIFO depths.** Command FIFO 4 entries; write FIFO 64 words; read FIFO 64 words.
- **Dropped pushes.** p0_cmd_en while p0_cmd_full is dropped silently. p0_wr_en while full is dropped and sets p0_wr_error.
- **Address mapping.** Word index = p0_cmd_byte_addr[MEM_ADDR_BITS+1:2]. byte_addr[1:0] is ignored. Index increments per beat and wraps modulo 2^MEM_ADDR_BITS.
- **Engine states.** IDLE → WAIT → WRITE / READ → IDLE.
  - IDLE pops a command when the command FIFO is not empty.
  - 1xx commands return to IDLE after the pop and cause no data beats.
  - WAIT lasts CMD_LATENCY cycles.
  - Bursts are bl+1 beats, one beat per cycle.
- **WRITE beat.** If the write FIFO is non-empty, pop it and write the unmasked bytes. If empty, pulse p0_wr_underrun, set p0_wr_error, leave RAM unchanged, and still advance the beat and address.
- **READ beat.** Push RAM[index] into the read FIFO. If the FIFO is full and no simultaneous p0_rd_en occurs, drop the word, pulse p0_rd_overflow and set p0_rd_error. The beat still advances.
- **Pop while empty.** p0_rd_en while empty is ignored and sets p0_rd_error.
- **Simultaneous push and pop.** A push and a pop on the same FIFO in the same cycle leave the count unchanged. This holds when full (read FIFO: no overflow) and when empty (write FIFO: no underrun is possible because the push lands first only when occupancy >0; on empty, the engine beat underruns).
- **Ordering.** Commands execute strictly in order. A read after a write to the same address returns the new data.

## Timing
- Command edge numbering: the cmd_en edge is edge 0.
  - Entry becomes visible (p0_cmd_empty=0) after edge 0.
  - Popped at edge 1.
  - First data beat at edge CMD_LATENCY+2.
- Read path: p0_rd_empty falls after edge CMD_LATENCY+2. Subsequent words arrive one per cycle.
- Write path: RAM is updated at the beat edge and is readable by any later command.
- Throughput: the next command can be popped on the edge after the last beat.
- Flag and count update timing: all flags and counts are registered and update on the edge of the push/pop.
- Reset mid-burst: the burst is abandoned, FIFOs are flushed, and RAM writes already made persist.

## Configuration
- MCB_RESP_REFRESH_STALL_EN: when defined, adds a REFRESH state.
  - A free-running 8-bit counter requests refresh on each wrap to 0.
  - The engine enters REFRESH from IDLE only (a request arriving mid-burst is deferred to the end of the burst) and stays there 8 cycles before popping again.
- When not defined: there is no REFRESH state, and latency is exactly as stated in Timing.

## Test plan
- **Calibration:** release reset → calib_done rises exactly 64 cycles later; p0_cmd_full is 1 until then.
- **Write-then-read burst:** push 32 words 0x600D0001..0x600D0020, then write bl=31 at addr 0x100, then read bl=31 at addr 0x100 → rd_data returns the 32 words in order, and the first word is visible after edge CMD_LATENCY+2 of the read cmd_en.
- **Byte mask:** write 0xFFFFFFFF, then write 0x12345678 with mask 0101 to the same address, then read → 0x12FF56FF.
- **Underrun:** write bl=3 with only 2 words queued → wr_underrun pulses twice, wr_error stays high, and the two unfed locations are unchanged.
- **Overflow and wrap:** read bl=63 twice with no pops → rd_count saturates at 64, rd_overflow pulses 64 times, rd_error=1. Separately, a read at the last word index with bl=1 wraps to word 0.
- **Reset mid-burst:** assert reset during the 10th beat of a 64-beat read → all flags return to reset values, and data written by earlier commands reads back intact after recalibration.

Source files
------------

// File: rtl/mcb_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : mcb_port_responder
// Brief    : Stand-in for the Spartan-6 MCB port-0 user interface. Accepts
//            commands, write data and read pops on the p0 FIFO ports and
//            serves them from an internal 32-bit RAM with MCB-like latency,
//            FIFO flags and error reporting.
// Options  : MCB_RESP_REFRESH_STALL_EN - adds a periodic 8-cycle REFRESH
//            stall taken only from IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module mcb_port_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int CALIB_CYCLES  = 64,
  parameter int CMD_LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        calib_done,
  input  logic        p0_cmd_en,
  input  logic [2:0]  p0_cmd_instr,
  input  logic [5:0]  p0_cmd_bl,
  input  logic [29:0] p0_cmd_byte_addr,
  output logic        p0_cmd_empty,
  output logic        p0_cmd_full,
  input  logic        p0_wr_en,
  input  logic [3:0]  p0_wr_mask,
  input  logic [31:0] p0_wr_data,
  output logic        p0_wr_full,
  output logic        p0_wr_empty,
  output logic [6:0]  p0_wr_count,
  output logic        p0_wr_underrun,
  output logic        p0_wr_error,
  input  logic        p0_rd_en,
  output logic [31:0] p0_rd_data,
  output logic        p0_rd_full,
  output logic        p0_rd_empty,
  output logic [6:0]  p0_rd_count,
  output logic        p0_rd_overflow,
  output logic        p0_rd_error
);

  localparam int c_CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int c_LAT_W = (CMD_LATENCY > 1) ? $clog2(CMD_LATENCY) : 1;
  localparam int c_DEPTH = 2 ** MEM_ADDR_BITS;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_WAIT    = 3'd1;
  localparam logic [2:0] c_ST_WRITE   = 3'd2;
  localparam logic [2:0] c_ST_READ    = 3'd3;
`ifdef MCB_RESP_REFRESH_STALL_EN
  localparam logic [2:0] c_ST_REFRESH = 3'd4;
`endif

  // ---------------------------------------------------------------- calibration
  logic [c_CAL_W-1:0] r_calib_cnt;
  logic               r_calib_done;

  // Count cycles after reset release; calib_done rises on the CALIB_CYCLES-th edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_calib_cnt  <= '0;
      r_calib_done <= 1'b0;
    end else if (!r_calib_done) begin
      r_calib_cnt <= r_calib_cnt + 1'b1;
      if (r_calib_cnt == c_CAL_W'(CALIB_CYCLES - 1)) r_calib_done <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- command FIFO
  logic [2:0]               r_cmd_instr [0:3];
  logic [5:0]               r_cmd_bl    [0:3];
  logic [MEM_ADDR_BITS-1:0] r_cmd_addr  [0:3];
  logic [1:0]               r_cmd_wptr, r_cmd_rptr;
  logic [2:0]               r_cmd_count;
  logic                     w_cmd_full, w_cmd_push, w_cmd_pop;
  logic [2:0]               w_head_instr;
  logic [5:0]               w_head_bl;
  logic [MEM_ADDR_BITS-1:0] w_head_addr;
  logic [2:0]               r_state;

  assign w_cmd_full   = !r_calib_done || (r_cmd_count == 3'd4);
  assign w_cmd_push   = p0_cmd_en && !w_cmd_full;
  assign w_head_instr = r_cmd_instr[r_cmd_rptr];
  assign w_head_bl    = r_cmd_bl[r_cmd_rptr];
  assign w_head_addr  = r_cmd_addr[r_cmd_rptr];

`ifdef MCB_RESP_REFRESH_STALL_EN
  logic [7:0] r_ref_cnt;
  logic       r_ref_pending;
  logic [2:0] r_ref_wait;
  // A pending refresh blocks the pop so the engine can stall from IDLE
  assign w_cmd_pop = (r_state == c_ST_IDLE) && (r_cmd_count != 3'd0) && !r_ref_pending;
`else
  assign w_cmd_pop = (r_state == c_ST_IDLE) && (r_cmd_count != 3'd0);
`endif

  // Command FIFO storage (no reset needed; guarded by count)
  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_instr[r_cmd_wptr] <= p0_cmd_instr;
      r_cmd_bl[r_cmd_wptr]    <= p0_cmd_bl;
      r_cmd_addr[r_cmd_wptr]  <= p0_cmd_byte_addr[MEM_ADDR_BITS+1:2];
    end
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 1'b1;
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 1'b1;
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_count <= r_cmd_count + 3'd1;
        2'b01:   r_cmd_count <= r_cmd_count - 3'd1;
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- engine
  logic [c_LAT_W-1:0]       r_wait_cnt;
  logic [5:0]               r_beat_left;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic                     r_is_read;
  logic                     w_wr_beat, w_rd_beat;

  assign w_wr_beat = (r_state == c_ST_WRITE);
  assign w_rd_beat = (r_state == c_ST_READ);

`ifdef MCB_RESP_REFRESH_STALL_EN
  // Free-running refresh timer; a request is latched on every wrap to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 8'd1;
      if ((r_state == c_ST_IDLE) && r_ref_pending) r_ref_pending <= 1'b0;
      if (r_ref_cnt == 8'hFF) r_ref_pending <= 1'b1;
    end
  end
`endif

  // Command sequencer: IDLE -> WAIT -> WRITE/READ (one beat per cycle) -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_wait_cnt  <= '0;
      r_beat_left <= '0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
`ifdef MCB_RESP_REFRESH_STALL_EN
      r_ref_wait  <= '0;
`endif
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_cmd_pop) begin
            // Refresh/no-op codes are consumed without any data beats
            if (!w_head_instr[2]) begin
              r_state     <= c_ST_WAIT;
              r_wait_cnt  <= c_LAT_W'(CMD_LATENCY - 1);
              r_is_read   <= w_head_instr[0];
              r_beat_left <= w_head_bl;
              r_addr      <= w_head_addr;
            end
          end
`ifdef MCB_RESP_REFRESH_STALL_EN
          else if (r_ref_pending) begin
            r_state    <= c_ST_REFRESH;
            r_ref_wait <= 3'd7;
          end
`endif
        end
        c_ST_WAIT: begin
          if (r_wait_cnt == '0) r_state <= r_is_read ? c_ST_READ : c_ST_WRITE;
          else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        c_ST_WRITE, c_ST_READ: begin
          // Address wraps naturally at the RAM depth
          r_addr <= r_addr + 1'b1;
          if (r_beat_left == 6'd0) r_state <= c_ST_IDLE;
          else                     r_beat_left <= r_beat_left - 6'd1;
        end
`ifdef MCB_RESP_REFRESH_STALL_EN
        c_ST_REFRESH: begin
          if (r_ref_wait == 3'd0) r_state <= c_ST_IDLE;
          else                    r_ref_wait <= r_ref_wait - 3'd1;
        end
`endif
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- write FIFO
  logic [31:0] r_wr_data_mem [0:63];
  logic [3:0]  r_wr_mask_mem [0:63];
  logic [5:0]  r_wr_wptr, r_wr_rptr;
  logic [6:0]  r_wr_count;
  logic        r_wr_underrun, r_wr_error;
  logic        w_wr_full, w_wr_empty, w_wr_push, w_wr_pop;
  logic [31:0] w_wr_head_data;
  logic [3:0]  w_wr_head_mask;

  assign w_wr_full      = (r_wr_count == 7'd64);
  assign w_wr_empty     = (r_wr_count == 7'd0);
  assign w_wr_push      = p0_wr_en && !w_wr_full;
  assign w_wr_pop       = w_wr_beat && !w_wr_empty;
  assign w_wr_head_data = r_wr_data_mem[r_wr_rptr];
  assign w_wr_head_mask = r_wr_mask_mem[r_wr_rptr];

  // Write FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr_push) begin
      r_wr_data_mem[r_wr_wptr] <= p0_wr_data;
      r_wr_mask_mem[r_wr_wptr] <= p0_wr_mask;
    end
  end

  // Write FIFO pointers, occupancy, underrun pulse and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_wptr     <= '0;
      r_wr_rptr     <= '0;
      r_wr_count    <= '0;
      r_wr_underrun <= 1'b0;
      r_wr_error    <= 1'b0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + 6'd1;
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + 6'd1;
      case ({w_wr_push, w_wr_pop})
        2'b10:   r_wr_count <= r_wr_count + 7'd1;
        2'b01:   r_wr_count <= r_wr_count - 7'd1;
        default: r_wr_count <= r_wr_count;
      endcase
      r_wr_underrun <= w_wr_beat && w_wr_empty;
      if ((w_wr_beat && w_wr_empty) || (p0_wr_en && w_wr_full)) r_wr_error <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RAM
  logic [31:0] r_ram [0:c_DEPTH-1];
  logic [31:0] w_ram_rdata;

  assign w_ram_rdata = r_ram[r_addr];

  // Byte-masked RAM write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!w_wr_head_mask[b]) r_ram[r_addr][8*b +: 8] <= w_wr_head_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read FIFO
  logic [31:0] r_rd_mem [0:63];
  logic [5:0]  r_rd_wptr, r_rd_rptr;
  logic [6:0]  r_rd_count;
  logic        r_rd_overflow, r_rd_error;
  logic        w_rd_full, w_rd_empty, w_rd_push, w_rd_pop;

  assign w_rd_full  = (r_rd_count == 7'd64);
  assign w_rd_empty = (r_rd_count == 7'd0);
  assign w_rd_pop   = p0_rd_en && !w_rd_empty;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the beat
  assign w_rd_push  = w_rd_beat && (!w_rd_full || w_rd_pop);

  // Read FIFO storage
  always_ff @(posedge clk) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= w_ram_rdata;
  end

  // Read FIFO pointers, occupancy, overflow pulse and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_wptr     <= '0;
      r_rd_rptr     <= '0;
      r_rd_count    <= '0;
      r_rd_overflow <= 1'b0;
      r_rd_error    <= 1'b0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + 6'd1;
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + 6'd1;
      case ({w_rd_push, w_rd_pop})
        2'b10:   r_rd_count <= r_rd_count + 7'd1;
        2'b01:   r_rd_count <= r_rd_count - 7'd1;
        default: r_rd_count <= r_rd_count;
      endcase
      r_rd_overflow <= w_rd_beat && !w_rd_push;
      if ((w_rd_beat && !w_rd_push) || (p0_rd_en && w_rd_empty)) r_rd_error <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  logic w_unused;
  assign w_unused = ^{p0_cmd_byte_addr[29:MEM_ADDR_BITS+2], p0_cmd_byte_addr[1:0],
                      w_head_instr[1]};

  assign calib_done     = r_calib_done;
  assign p0_cmd_empty   = (r_cmd_count == 3'd0);
  assign p0_cmd_full    = w_cmd_full;
  assign p0_wr_full     = w_wr_full;
  assign p0_wr_empty    = w_wr_empty;
  assign p0_wr_count    = r_wr_count;
  assign p0_wr_underrun = r_wr_underrun;
  assign p0_wr_error    = r_wr_error;
  assign p0_rd_data     = w_rd_empty ? 32'd0 : r_rd_mem[r_rd_rptr];
  assign p0_rd_full     = w_rd_full;
  assign p0_rd_empty    = w_rd_empty;
  assign p0_rd_count    = r_rd_count;
  assign p0_rd_overflow = r_rd_overflow;
  assign p0_rd_error    = r_rd_error;

endmodule
`default_nettype wire

// File: tb/tb_mcb_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcb_port_responder
// Brief    : Directed bench for mcb_port_responder: calibration, masked
//            single-beat vectors, burst latency, underrun, overflow, address
//            wrap and reset in the middle of a burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcb_port_responder;

  localparam int c_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        calib_done;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_empty, p0_cmd_full;
  logic        p0_wr_en;
  logic [3:0]  p0_wr_mask;
  logic [31:0] p0_wr_data;
  logic        p0_wr_full, p0_wr_empty;
  logic [6:0]  p0_wr_count;
  logic        p0_wr_underrun, p0_wr_error;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_full, p0_rd_empty;
  logic [6:0]  p0_rd_count;
  logic        p0_rd_overflow, p0_rd_error;

  int checks   = 0;
  int failures = 0;

  mcb_port_responder #(
    .MEM_ADDR_BITS(10),
    .CALIB_CYCLES (64),
    .CMD_LATENCY  (c_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .calib_done      (calib_done),
    .p0_cmd_en       (p0_cmd_en),
    .p0_cmd_instr    (p0_cmd_instr),
    .p0_cmd_bl       (p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr),
    .p0_cmd_empty    (p0_cmd_empty),
    .p0_cmd_full     (p0_cmd_full),
    .p0_wr_en        (p0_wr_en),
    .p0_wr_mask      (p0_wr_mask),
    .p0_wr_data      (p0_wr_data),
    .p0_wr_full      (p0_wr_full),
    .p0_wr_empty     (p0_wr_empty),
    .p0_wr_count     (p0_wr_count),
    .p0_wr_underrun  (p0_wr_underrun),
    .p0_wr_error     (p0_wr_error),
    .p0_rd_en        (p0_rd_en),
    .p0_rd_data      (p0_rd_data),
    .p0_rd_full      (p0_rd_full),
    .p0_rd_empty     (p0_rd_empty),
    .p0_rd_count     (p0_rd_count),
    .p0_rd_overflow  (p0_rd_overflow),
    .p0_rd_error     (p0_rd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
    p0_wr_en   = 1'b1;
    p0_wr_data = data;
    p0_wr_mask = mask;
    tick();
    p0_wr_en   = 1'b0;
  endtask

  // Issues one command; returns #1 after the cmd_en edge (edge 0)
  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    int n = 0;
    while (p0_cmd_full && n < 300) begin tick(); n++; end
    if (p0_cmd_full) begin
      checks++; failures++;
      $display("FAIL send_cmd timeout: cmd_full=%0b required 0", p0_cmd_full);
    end
    p0_cmd_en        = 1'b1;
    p0_cmd_instr     = instr;
    p0_cmd_bl        = bl;
    p0_cmd_byte_addr = addr;
    tick();
    p0_cmd_en        = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    int n = 0;
    while (p0_rd_empty && n < 200) begin tick(); n++; end
    if (p0_rd_empty) begin
      checks++; failures++;
      $display("FAIL %s timeout: rd_empty=1 required 0", name);
      return;
    end
    check(name, p0_rd_data, exp);
    p0_rd_en = 1'b1;
    tick();
    p0_rd_en = 1'b0;
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, " calib_done"}, 32'(calib_done), 32'd0);
    check({tag, " cmd_full"},   32'(p0_cmd_full), 32'd1);
    check({tag, " cmd_empty"},  32'(p0_cmd_empty), 32'd1);
    check({tag, " wr_empty"},   32'(p0_wr_empty), 32'd1);
    check({tag, " rd_empty"},   32'(p0_rd_empty), 32'd1);
    check({tag, " rd_full"},    32'(p0_rd_full), 32'd0);
    check({tag, " rd_count"},   32'(p0_rd_count), 32'd0);
    check({tag, " wr_count"},   32'(p0_wr_count), 32'd0);
    check({tag, " rd_data"},    p0_rd_data, 32'd0);
    check({tag, " rd_error"},   32'(p0_rd_error), 32'd0);
    check({tag, " wr_error"},   32'(p0_wr_error), 32'd0);
  endtask

  task automatic wait_calib(output int n);
    n = 0;
    while (!calib_done && n < 300) begin tick(); n++; end
  endtask

  initial begin
    int  n;
    int  pulses;
    bit  full_ok;

    // address / data / mask / expected readback
    vecs[0] = '{30'h040,  32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF};
    vecs[1] = '{30'h040,  32'h12345678, 4'b0101, 32'h12FF56FF};
    vecs[2] = '{30'h043,  32'hAABBCCDD, 4'b1110, 32'h12FF56DD};
    vecs[3] = '{30'hFFC,  32'hDEADBEEF, 4'b0000, 32'hDEADBEEF};
    vecs[4] = '{30'h1000, 32'hCAFEF00D, 4'b0000, 32'hCAFEF00D};
    vecs[5] = '{30'h00C,  32'h5A5A5A5A, 4'b0000, 32'h5A5A5A5A};

    reset = 1'b1; p0_cmd_en = 1'b0; p0_cmd_instr = '0; p0_cmd_bl = '0;
    p0_cmd_byte_addr = '0; p0_wr_en = 1'b0; p0_wr_mask = '0; p0_wr_data = '0;
    p0_rd_en = 1'b0;
    repeat (3) tick();
    check_reset_flags("reset");

    // Calibration: calib_done rises on the 64th edge after release
    reset   = 1'b0;
    n       = 0;
    full_ok = 1'b1;
    while (!calib_done && n < 300) begin
      if (!p0_cmd_full) full_ok = 1'b0;
      tick();
      n++;
    end
    check("calib_cycles", 32'(n), 32'd64);
    check("cmd_full_during_calib", 32'(full_ok), 32'd1);
    check("cmd_full_after_calib", 32'(p0_cmd_full), 32'd0);

    // Single-beat masked write then read-back vectors
    for (int i = 0; i < 6; i++) begin
      push_wr(vecs[i].wdata, vecs[i].mask);
      send_cmd(3'b000, 6'd0, vecs[i].addr);
      send_cmd(3'b001, 6'd0, vecs[i].addr);
      pop_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // 32-word burst write then read, with first-word latency check
    for (int i = 0; i < 32; i++) push_wr(32'h600D0001 + 32'(i), 4'b0000);
    check("wr_count_32", 32'(p0_wr_count), 32'd32);
    send_cmd(3'b010, 6'd31, 30'h100);
    n = 0;
    while (!p0_wr_empty && n < 200) begin tick(); n++; end
    check("burst_wr_drained", 32'(p0_wr_empty), 32'd1);
    repeat (2) tick();
    send_cmd(3'b011, 6'd31, 30'h100);
    check("cmd_visible_edge0", 32'(p0_cmd_empty), 32'd0);
    tick();
    check("cmd_popped_edge1", 32'(p0_cmd_empty), 32'd1);
    repeat (c_LAT) tick();
    check("rd_empty_before_beat", 32'(p0_rd_empty), 32'd1);
    tick();
    check("rd_empty_at_beat", 32'(p0_rd_empty), 32'd0);
    check("first_word_at_beat", p0_rd_data, 32'h600D0001);
    for (int i = 0; i < 32; i++) pop_check($sformatf("burst%0d", i), 32'h600D0001 + 32'(i));

    // No-op command: consumed without producing data
    send_cmd(3'b100, 6'd5, 30'h0);
    repeat (c_LAT + 10) tick();
    check("noop_cmd_empty", 32'(p0_cmd_empty), 32'd1);
    check("noop_no_data", 32'(p0_rd_count), 32'd0);

    // Underrun: prefill 4 words, then write bl=3 with only 2 words queued
    for (int i = 0; i < 4; i++) push_wr(32'hA5A50000 + 32'(i), 4'b0000);
    send_cmd(3'b000, 6'd3, 30'h200);
    repeat (20) tick();
    check("wr_error_before_underrun", 32'(p0_wr_error), 32'd0);
    push_wr(32'h11111111, 4'b0000);
    push_wr(32'h22222222, 4'b0000);
    send_cmd(3'b000, 6'd3, 30'h200);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (p0_wr_underrun) pulses++;
      tick();
    end
    check("underrun_pulses", 32'(pulses), 32'd2);
    check("wr_error_sticky", 32'(p0_wr_error), 32'd1);
    send_cmd(3'b001, 6'd3, 30'h200);
    pop_check("underrun_w0", 32'h11111111);
    pop_check("underrun_w1", 32'h22222222);
    pop_check("underrun_w2", 32'hA5A50002);
    pop_check("underrun_w3", 32'hA5A50003);

    // Overflow: two 64-beat reads with no pops
    check("rd_error_before_ovf", 32'(p0_rd_error), 32'd0);
    send_cmd(3'b001, 6'd63, 30'h0);
    send_cmd(3'b001, 6'd63, 30'h0);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (p0_rd_overflow) pulses++;
      tick();
    end
    check("ovf_pulses", 32'(pulses), 32'd64);
    check("ovf_rd_count", 32'(p0_rd_count), 32'd64);
    check("ovf_rd_full", 32'(p0_rd_full), 32'd1);
    check("ovf_rd_error", 32'(p0_rd_error), 32'd1);
    p0_rd_en = 1'b1;
    repeat (64) tick();
    p0_rd_en = 1'b0;
    check("drained_rd_empty", 32'(p0_rd_empty), 32'd1);

    // Address wrap: last word index then word 0
    send_cmd(3'b001, 6'd1, 30'hFFC);
    pop_check("wrap_last", 32'hDEADBEEF);
    pop_check("wrap_first", 32'hCAFEF00D);

    // Reset during the 10th beat of a 64-beat read
    send_cmd(3'b001, 6'd63, 30'h100);
    n = 0;
    while (p0_rd_count != 7'd9 && n < 200) begin tick(); n++; end
    check("midburst_count9", 32'(p0_rd_count), 32'd9);
    reset = 1'b1;
    #1;
    check_reset_flags("midreset");
    repeat (2) tick();
    reset = 1'b0;
    wait_calib(n);
    check("recal_cycles", 32'(n), 32'd64);
    send_cmd(3'b001, 6'd3, 30'h100);
    for (int i = 0; i < 4; i++) pop_check($sformatf("persist%0d", i), 32'h600D0001 + 32'(i));

    // Pop while empty sets the sticky read error and changes nothing else
    p0_rd_en = 1'b1;
    tick();
    p0_rd_en = 1'b0;
    check("pop_empty_error", 32'(p0_rd_error), 32'd1);
    check("pop_empty_count", 32'(p0_rd_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
